// File: rtl/poly_alu_if.sv
// poly_alu streaming bus: operation request, serial coefficient input
// and result write strobe, grouped for the host (master) and unit (slave).
interface poly_alu_if #(
  parameter int W = 8
);
  logic         rd;
  logic [1:0]   mode;
  logic [W-1:0] X;
  logic         X_vld;
  logic         busy;
  logic         wr;
  logic [W-1:0] R;
  logic         R_last;

  modport master (
    output rd, mode, X, X_vld,
    input  busy, wr, R, R_last
  );

  modport slave (
    input  rd, mode, X, X_vld,
    output busy, wr, R, R_last
  );
endinterface

// File: rtl/poly_alu.sv
// Polynomial add/sub/mul/copy unit with serial load and streamed result.
// Define POLY_ALU_SAT_EN to saturate results instead of wrapping.
module poly_alu #(
  parameter int W = 8,
  parameter int N = 6
) (
  input logic       Clk,
  input logic       Rst_n,
  poly_alu_if.slave io
);
  localparam int AW = $clog2(2*N);
  localparam int IW = $clog2(N);
  localparam int CW = 2*W + AW;
  localparam int L2 = 2*N - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_mode;
  logic [W-1:0]  r_a [N];
  logic [W-1:0]  r_b [N];
  logic [CW-1:0] r_c [L2];
  logic [AW-1:0] r_cnt;
  logic          r_wr;
  logic          r_last;
  logic [W-1:0]  r_r;

  logic          w_mul;
  logic [AW-1:0] w_len;
  logic [IW-1:0] w_idx;
  logic          w_ld_done;
  logic          w_cmp_done;
  logic          w_out_done;
  logic [W-1:0]  w_rval;

  assign w_mul      = (r_mode == 2'b10);
  assign w_len      = w_mul ? AW'(L2) : AW'(N);
  assign w_idx      = r_cnt[IW-1:0];
  assign w_ld_done  = io.X_vld && (r_cnt == AW'(N-1));
  assign w_cmp_done = !w_mul || (r_cnt == AW'(N-1));
  assign w_out_done = (r_cnt == w_len);

`ifdef POLY_ALU_SAT_EN
  assign w_rval = (|r_c[r_cnt][CW-1:W]) ? '1 : r_c[r_cnt][W-1:0];
`else
  assign w_rval = r_c[r_cnt][W-1:0];
`endif

  assign io.busy   = (r_state != S_IDLE);
  assign io.wr     = r_wr;
  assign io.R      = r_r;
  assign io.R_last = r_last;

  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (io.rd)      w_next = S_LOAD_A;
      S_LOAD_A:  if (w_ld_done)  w_next = S_LOAD_B;
      S_LOAD_B:  if (w_ld_done)  w_next = S_COMPUTE;
      S_COMPUTE: if (w_cmp_done) w_next = S_OUTPUT;
      S_OUTPUT:  if (w_out_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_mode <= '0;
      r_cnt  <= '0;
      r_wr   <= 1'b0;
      r_last <= 1'b0;
      r_r    <= '0;
      for (int i = 0; i < N; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      for (int i = 0; i < L2; i++) r_c[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (io.rd) r_mode <= io.mode;
        end
        S_LOAD_A: if (io.X_vld) begin
          r_a[w_idx] <= io.X;
          r_cnt <= w_ld_done ? '0 : r_cnt + 1'b1;
        end
        S_LOAD_B: if (io.X_vld) begin
          r_b[w_idx] <= io.X;
          r_cnt <= w_ld_done ? '0 : r_cnt + 1'b1;
          if (w_ld_done)
            for (int i = 0; i < L2; i++) r_c[i] <= '0;
        end
        S_COMPUTE: begin
          if (w_mul) begin
            // one row of the convolution per cycle
            for (int j = 0; j < N; j++)
              r_c[r_cnt + AW'(j)] <= r_c[r_cnt + AW'(j)]
                + CW'(r_a[w_idx]) * CW'(r_b[j]);
            r_cnt <= w_cmp_done ? '0 : r_cnt + 1'b1;
          end else begin
            for (int i = 0; i < N; i++) begin
              unique case (r_mode)
                2'b01: begin
`ifdef POLY_ALU_SAT_EN
                  r_c[i] <= (r_a[i] < r_b[i]) ? '0
                          : CW'(r_a[i] - r_b[i]);
`else
                  r_c[i] <= CW'(r_a[i] - r_b[i]);
`endif
                end
                2'b11:   r_c[i] <= CW'(r_a[i]);
                default: r_c[i] <= CW'(r_a[i]) + CW'(r_b[i]);
              endcase
            end
            r_cnt <= '0;
          end
        end
        S_OUTPUT: begin
          if (w_out_done) begin
            r_wr   <= 1'b0;
            r_last <= 1'b0;
          end else begin
            r_wr   <= 1'b1;
            r_r    <= w_rval;
            r_last <= (r_cnt == w_len - 1'b1);
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_alu.sv
// Directed bench for poly_alu: table of operations plus reset-abort,
// gapped-load and back-to-back sequences.
module tb_poly_alu;
  localparam int W  = 8;
  localparam int N  = 6;
  localparam int LM = 2*N - 1;
`ifdef POLY_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  poly_alu_if #(.W(W)) bus();

  poly_alu #(.W(W), .N(N)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .io    (bus.slave)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    int         a [N];
    int         b [N];
    int         len;
    int         e [LM];
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit gap, input bit poke);
    int lat;
    int elat;
    bus.rd   = 1'b1;
    bus.mode = v.mode;
    @(negedge clk);
    bus.rd   = 1'b0;
    bus.mode = ~v.mode;
    chk({v.name, "/busy_start"}, int'(bus.busy), 1);
    for (int k = 0; k < N; k++) begin
      if (gap) begin
        bus.X_vld = 1'b0;
        @(negedge clk);
      end
      bus.X     = W'(v.a[k]);
      bus.X_vld = 1'b1;
      @(negedge clk);
    end
    bus.rd = poke;
    for (int k = 0; k < N; k++) begin
      if (gap) begin
        bus.X_vld = 1'b0;
        @(negedge clk);
      end
      bus.X     = W'(v.b[k]);
      bus.X_vld = 1'b1;
      @(negedge clk);
    end
    bus.X_vld = 1'b0;
    bus.rd    = 1'b0;
    lat = 1;
    while (!bus.wr && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    elat = (v.mode == 2'b10) ? N + 1 : 2;
    chk({v.name, "/latency"}, lat - 1, elat);
    for (int k = 0; k < v.len; k++) begin
      bus.rd = poke && (k == 0);
      chk($sformatf("%s/wr[%0d]", v.name, k), int'(bus.wr), 1);
      chk($sformatf("%s/R[%0d]", v.name, k), int'(bus.R), v.e[k]);
      chk($sformatf("%s/last[%0d]", v.name, k), int'(bus.R_last),
          (k == v.len - 1) ? 1 : 0);
      @(negedge clk);
    end
    bus.rd = 1'b0;
    chk({v.name, "/wr_end"}, int'(bus.wr), 0);
    chk({v.name, "/last_end"}, int'(bus.R_last), 0);
    chk({v.name, "/busy_end"}, int'(bus.busy), 0);
    chk({v.name, "/R_hold"}, int'(bus.R), v.e[v.len-1]);
    if (poke) begin
      @(negedge clk);
      chk({v.name, "/no_extra_op"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    int nbusy;
    bus.rd    = 1'b0;
    bus.mode  = 2'b00;
    bus.X     = '0;
    bus.X_vld = 1'b0;

    vt[0].name = "add";   vt[0].mode = 2'b00; vt[0].len = N;
    vt[0].a = '{1, 2, 3, 4, 5, 6};
    vt[0].b = '{10, 20, 30, 40, 50, 60};
    vt[0].e = '{11, 22, 33, 44, 55, 66, 0, 0, 0, 0, 0};

    vt[1].name = "mul";   vt[1].mode = 2'b10; vt[1].len = LM;
    vt[1].a = '{1, 1, 0, 0, 0, 0};
    vt[1].b = '{1, 1, 0, 0, 0, 0};
    vt[1].e = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    vt[2].name = "add_ovf"; vt[2].mode = 2'b00; vt[2].len = N;
    vt[2].a = '{200, 3, 0, 0, 0, 250};
    vt[2].b = '{100, 4, 0, 0, 0, 10};
    vt[2].e = '{SAT ? 255 : 44, 7, 0, 0, 0, SAT ? 255 : 4,
                0, 0, 0, 0, 0};

    vt[3].name = "sub";   vt[3].mode = 2'b01; vt[3].len = N;
    vt[3].a = '{5, 10, 0, 0, 0, 9};
    vt[3].b = '{7, 3, 0, 0, 0, 9};
    vt[3].e = '{SAT ? 0 : 254, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    vt[4].name = "mul_ovf"; vt[4].mode = 2'b10; vt[4].len = LM;
    vt[4].a = '{16, 16, 0, 0, 0, 0};
    vt[4].b = '{17, 0, 0, 0, 0, 0};
    vt[4].e = '{SAT ? 255 : 16, SAT ? 255 : 16,
                0, 0, 0, 0, 0, 0, 0, 0, 0};

    vt[5].name = "copy";  vt[5].mode = 2'b11; vt[5].len = N;
    vt[5].a = '{9, 8, 7, 6, 5, 4};
    vt[5].b = '{100, 101, 102, 103, 104, 105};
    vt[5].e = '{9, 8, 7, 6, 5, 4, 0, 0, 0, 0, 0};

    vt[6].name = "mul_b2b"; vt[6].mode = 2'b10; vt[6].len = LM;
    vt[6].a = '{1, 2, 3, 0, 0, 0};
    vt[6].b = '{4, 5, 0, 0, 0, 0};
    vt[6].e = '{4, 13, 22, 15, 0, 0, 0, 0, 0, 0, 0};

    vt[7].name = "ones";  vt[7].mode = 2'b00; vt[7].len = N;
    vt[7].a = '{1, 1, 1, 1, 1, 1};
    vt[7].b = '{1, 1, 1, 1, 1, 1};
    vt[7].e = '{2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst/busy", int'(bus.busy), 0);
    chk("rst/wr", int'(bus.wr), 0);
    chk("rst/R", int'(bus.R), 0);
    chk("rst/R_last", int'(bus.R_last), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_op(vt[i], 1'b0, 1'b0);

    vt[0].name = "add_gap";
    run_op(vt[0], 1'b1, 1'b1);

    // abort an add after three A words
    bus.rd   = 1'b1;
    bus.mode = 2'b00;
    @(negedge clk);
    bus.rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.X     = 8'd77;
      bus.X_vld = 1'b1;
      @(negedge clk);
    end
    bus.X_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort/busy", int'(bus.busy), 0);
    chk("abort/wr", int'(bus.wr), 0);
    nwr = 0;
    nbusy = 0;
    repeat (12) begin
      @(negedge clk);
      nwr   += int'(bus.wr);
      nbusy += int'(bus.busy);
    end
    chk("abort/wr_count", nwr, 0);
    chk("abort/busy_count", nbusy, 0);
    run_op(vt[7], 1'b0, 1'b0);

    run_op(vt[5], 1'b0, 1'b0);
    run_op(vt[6], 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_alu.md
Name: poly_alu

Overview:
- Parametrised polynomial arithmetic unit; successor to the fixed 6-coefficient polynomial adder.
- Loads two coefficient vectors A and B serially on a shared input bus.
- Computes A+B, A-B, A*B (full convolution) or passes A through, selected per operation.
- Streams the result coefficients out with a write strobe to the downstream consumer.

Parameters:
W, 8, coefficient width in bits (unsigned)
N, 6, coefficients per input polynomial (degree N-1); N >= 2
AW, $clog2(2*N), index/counter width (derived; not overridden)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst_n  in  1  synchronous reset, active low
rd  in  1  start request; sampled only in IDLE
mode  in  2  operation, captured with rd: 00 add, 01 sub (A-B), 10 mul, 11 copy A
X  in  W  input coefficient, lowest degree first
X_vld  in  1  X valid this cycle
busy  out  1  high in every state except IDLE
wr  out  1  R valid this cycle
R  out  W  output coefficient, lowest degree first
R_last  out  1  high with wr on final output coefficient

Behaviour:
- Reset (Rst_n=0 at posedge): state IDLE; wr=0, R=0, R_last=0, busy=0; A, B, result registers and counters cleared. Applies from any state, aborting any operation in progress; no partial output follows.
- States: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> OUTPUT -> IDLE.
- IDLE:
  - rd=1 captures mode and moves to LOAD_A next cycle.
  - X/X_vld ignored in IDLE.
- LOAD_A:
  - Each cycle with X_vld=1 stores X into A[k], k=0..N-1.
  - After N accepted words, moves to LOAD_B.
  - Gaps (X_vld=0) allowed, unbounded.
- LOAD_B: same as LOAD_A into B. After N accepted words, moves to COMPUTE.
- rd is ignored while busy=1.
- COMPUTE, add/sub/copy:
  - 1 cycle.
  - C[i] = A[i]+B[i], A[i]-B[i] or A[i], each modulo 2^W.
- COMPUTE, mul:
  - N cycles. Cycle i (0..N-1) adds A[i]*B[j] into C[i+j] for all j.
  - Accumulators are 2W+AW bits wide; C cleared on entry to COMPUTE.
  - Output value is accumulator modulo 2^W.
- OUTPUT:
  - Starts the cycle after COMPUTE ends.
  - wr=1 for exactly L consecutive cycles: L=N for add/sub/copy, L=2N-1 for mul.
  - R=C[0..L-1] in order; R_last=1 only with C[L-1].
  - No backpressure.
  - Next cycle returns to IDLE with wr=0, R_last=0. R holds its last value.
- Latency, last B accept edge to first wr=1: 2 cycles (add/sub/copy); N+1 cycles (mul).
- A new rd is accepted in the first IDLE cycle after OUTPUT, giving back-to-back operation with 1 idle cycle.
- mode changes after capture have no effect on the running operation.

Optional Feature:
- Macro: POLY_ALU_SAT_EN.
- Defined: results saturate instead of wrapping.
  - add/mul: clamp to 2^W-1 when the true value exceeds it.
  - sub: clamp to 0 when A[i]<B[i].
  - copy: unaffected.
- Undefined: all results modulo 2^W as above; no saturation logic synthesised.

Test Plan:
- Add, N=6, W=8: A=1,2,3,4,5,6; B=10,20,30,40,50,60 -> wr 6 cycles, R=11,22,33,44,55,66; R_last on 66; first wr 2 cycles after last B.
- Mul: A=1,1,0,0,0,0; B=1,1,0,0,0,0 -> wr 11 cycles, R=1,2,1,0,0,0,0,0,0,0,0; first wr 7 cycles after last B.
- Overflow: add A[0]=200, B[0]=100 -> R[0]=44 (macro off) / 255 (macro on). Sub A[0]=5, B[0]=7 -> R[0]=254 (off) / 0 (on).
- Load with X_vld toggling 1/0 each cycle and rd pulsed during LOAD_B and OUTPUT -> same results as gap-free load; no extra operation started.
- Rst_n=0 for 1 cycle after 3 A words -> busy=0 next cycle, no wr. A fresh add of all-ones + all-ones -> R=2 x6, no stale data.
- Copy mode, A=9,8,7,6,5,4 -> R=9,8,7,6,5,4. Immediately followed by a mul op -> accepted after 1 idle cycle, correct result.
